// File: rtl/sat_mac_unit.sv
// sat_mac_unit: iterative signed multiply with product clamp, saturating accumulate; SAT_MAC_STICKY_SAT_EN makes sat_flag sticky
//   clk, rst_n (async active-low) | in_valid/in_ready handshake, in_a/in_b signed operands,
//   acc_clear (IDLE only) | out_valid pulse, acc_out accumulator, sat_flag saturation indicator
module sat_mac_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] acc_out,
  output logic             sat_flag
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] MAX_MAG = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MIN_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0] mplr_q, mplr_d, acc_q, acc_d;
  logic sign_q, sign_d, sat_q, sat_d, ov_q, ov_d;
  logic [WIDTH-1:0] a_mag, b_mag, p_val, sum, acc_sat;
  logic p_pos_ovf, p_neg_ovf, s_pos_ovf, s_neg_ovf, sat_ev;
  assign in_ready  = state_q == IDLE;
  assign out_valid = ov_q;
  assign acc_out   = acc_q;
  assign sat_flag  = sat_q;
  always_comb begin
    // magnitudes are unsigned so |MIN| = 2^(WIDTH-1) fits without overflow
    a_mag     = in_a[WIDTH-1] ? -in_a : in_a;
    b_mag     = in_b[WIDTH-1] ? -in_b : in_b;
    // a negative result may reach magnitude 2^(WIDTH-1), a positive one only MAX
    p_pos_ovf = !sign_q && prod_q > MAX_MAG;
    p_neg_ovf = sign_q && prod_q > MIN_MAG;
    p_val     = p_pos_ovf ? MAX : p_neg_ovf ? MIN : sign_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    sum       = acc_q + p_val;
    s_pos_ovf = !acc_q[WIDTH-1] && !p_val[WIDTH-1] && sum[WIDTH-1];
    s_neg_ovf = acc_q[WIDTH-1] && p_val[WIDTH-1] && !sum[WIDTH-1];
    acc_sat   = s_pos_ovf ? MAX : s_neg_ovf ? MIN : sum;
    sat_ev    = p_pos_ovf || p_neg_ovf || s_pos_ovf || s_neg_ovf;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    ov_d    = 1'b0;
    if (state_q == IDLE) begin
      if (acc_clear) begin
        acc_d = '0;
        sat_d = 1'b0;
      end
      if (in_valid) begin
        state_d = MUL;
        cnt_d   = CW'(WIDTH-1);
        mcand_d = {{WIDTH{1'b0}}, a_mag};
        mplr_d  = b_mag;
        prod_d  = '0;
        sign_d  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
      end
    end else if (state_q == MUL) begin
      prod_d  = prod_q + (mplr_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == '0 ? ACC : MUL;
    end else begin
      acc_d   = acc_sat;
`ifdef SAT_MAC_STICKY_SAT_EN
      sat_d   = sat_q || sat_ev;
`else
      sat_d   = sat_ev;
`endif
      ov_d    = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_sat_mac_unit.sv
// tb_sat_mac_unit: randomized and directed checks of sat_mac_unit against an integer-arithmetic model
module tb_sat_mac_unit;
  localparam int W = 8;
  logic clk, rst_n, in_valid, in_ready, acc_clear, out_valid, sat_flag;
  logic [W-1:0] in_a, in_b, acc_out;
  int n_tests, n_fail, m_acc;
  bit m_sat;
  sat_mac_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clear(acc_clear), .out_valid(out_valid),
    .acc_out(acc_out), .sat_flag(sat_flag)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic model(input int a, input int b, input bit clr);
    int p, s;
    bit ev;
    if (clr) begin
      m_acc = 0;
      m_sat = 0;
    end
    p  = a * b;
    ev = 0;
    if (p > 127) begin p = 127; ev = 1; end
    if (p < -128) begin p = -128; ev = 1; end
    s = m_acc + p;
    if (s > 127) begin s = 127; ev = 1; end
    if (s < -128) begin s = -128; ev = 1; end
    m_acc = s;
`ifdef SAT_MAC_STICKY_SAT_EN
    m_sat = m_sat | ev;
`else
    m_sat = ev;
`endif
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr, output int lat, output bit busy_bad);
    int g;
    g = 0;
    while (!in_ready && g < 40) begin
      @(posedge clk); #1; g++;
    end
    in_valid = 1'b1; in_a = a; in_b = b; acc_clear = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clear = 1'b0; in_a = $urandom; in_b = $urandom;
    lat = 1; busy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1;
      @(posedge clk); #1; lat++;
    end
    model(int'($signed(a)), int'($signed(b)), clr);
  endtask
  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; acc_clear = 1'b0; in_a = '0; in_b = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (acc_out !== 8'h00) begin n_fail++; $display("FAIL reset_acc got %h want 00", acc_out); end
    n_tests++; if ({in_ready, out_valid, sat_flag} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got rdy/ov/sat=%b want 100", {in_ready, out_valid, sat_flag}); end
    rst_n = 1'b1;
    m_acc = 0; m_sat = 0;
  endtask
  task automatic test_basic;
    int lat;
    bit bb;
    do_op(8'd3, 8'd4, 1'b1, lat, bb);
    n_tests++; if (lat !== W + 2) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, W + 2); end
    n_tests++; if (bb) begin n_fail++; $display("FAIL basic_busy got in_ready=1 while busy want 0"); end
    n_tests++; if (acc_out !== 8'd12) begin n_fail++; $display("FAIL basic_acc got %0d want 12", acc_out); end
    n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b want 0", sat_flag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_at_out got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got %b want 0", out_valid); end
  endtask
  task automatic test_sat_add;
    int lat;
    bit bb;
    do_op(8'd12, 8'd10, 1'b1, lat, bb);
    do_op(8'd10, 8'd1, 1'b0, lat, bb);
    n_tests++; if (acc_out !== 8'd127 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL satadd_pos got acc=%0d sat=%b want 127/1", acc_out, sat_flag); end
    do_op(-8'sd5, 8'd1, 1'b0, lat, bb);
    n_tests++; if (acc_out !== 8'd122) begin n_fail++; $display("FAIL satadd_after got %0d want 122", acc_out); end
    n_tests++; if (sat_flag !== m_sat) begin n_fail++; $display("FAIL satadd_flag got %b want %b", sat_flag, m_sat); end
  endtask
  task automatic test_neg;
    int lat;
    bit bb;
    do_op(-8'sd16, 8'd8, 1'b1, lat, bb);
    n_tests++; if (acc_out !== 8'h80 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL neg_min got acc=%h sat=%b want 80/0", acc_out, sat_flag); end
    do_op(-8'sd1, 8'd1, 1'b0, lat, bb);
    n_tests++; if (acc_out !== 8'h80 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL neg_ovf got acc=%h sat=%b want 80/1", acc_out, sat_flag); end
  endtask
  task automatic test_prod_clamp;
    int lat;
    bit bb;
    do_op(8'd16, 8'd16, 1'b1, lat, bb);
    n_tests++; if (acc_out !== 8'd127 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL clamp_256 got acc=%0d sat=%b want 127/1", acc_out, sat_flag); end
    do_op(8'h80, 8'h80, 1'b1, lat, bb);
    n_tests++; if (acc_out !== 8'd127 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL clamp_minmin got acc=%0d sat=%b want 127/1", acc_out, sat_flag); end
    do_op(8'h80, 8'd1, 1'b1, lat, bb);
    n_tests++; if (acc_out !== 8'h80 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL clamp_min1 got acc=%h sat=%b want 80/0", acc_out, sat_flag); end
  endtask
  task automatic test_clear_alone;
    int lat;
    bit bb;
    do_op(8'd100, 8'd2, 1'b1, lat, bb);
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    m_acc = 0; m_sat = 0;
    n_tests++; if (acc_out !== 8'd0 || sat_flag !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_alone got acc=%0d sat=%b ov=%b want 0/0/0", acc_out, sat_flag, out_valid); end
  endtask
  task automatic test_back_to_back;
    int cyc, k;
    cyc = 0; k = 0;
    in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
    while (k < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      acc_clear = cyc == 15;
      if (out_valid) begin
        k++;
        if (k == 4) in_valid = 1'b0;
        n_tests++; if (cyc !== 10 * k) begin n_fail++; $display("FAIL b2b_cycle%0d got %0d want %0d", k, cyc, 10 * k); end
        n_tests++; if (acc_out !== 8'(6 * k)) begin n_fail++; $display("FAIL b2b_acc%0d got %0d want %0d", k, acc_out, 6 * k); end
      end
    end
    in_valid = 1'b0; acc_clear = 1'b0;
    n_tests++; if (k !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", k); end
    m_acc = 24; m_sat = 0;
  endtask
  task automatic test_random;
    int lat;
    bit bb;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'(int'($urandom_range(0, 15)) - 8);
      b = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'(int'($urandom_range(0, 15)) - 8);
      do_op(a, b, $urandom_range(0, 7) == 0, lat, bb);
      n_tests++; if (acc_out !== 8'(m_acc) || sat_flag !== m_sat || lat !== W + 2 || bb) begin
        n_fail++; $display("FAIL rand%0d a=%0d b=%0d got acc=%0d sat=%b lat=%0d want acc=%0d sat=%b lat=%0d", i, $signed(a), $signed(b), $signed(acc_out), sat_flag, lat, m_acc, m_sat, W + 2);
      end
    end
  endtask
  task automatic test_abort;
    int lat;
    bit bb, seen;
    do_op(8'd7, 8'd3, 1'b1, lat, bb);
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (acc_out !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_state got acc=%0d rdy=%b ov=%b want 0/1/0", acc_out, in_ready, out_valid); end
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_pulse got out_valid=1 want none"); end
    m_acc = 0; m_sat = 0;
  endtask
  initial begin
    n_tests = 0; n_fail = 0;
    test_reset;
    test_basic;
    test_sat_add;
    test_neg;
    test_prod_clamp;
    test_clear_alone;
    test_back_to_back;
    test_random;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
